// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial adder. One full-add stage processes an operand bit
//            pair per clock, LSB first, with the carry-out registered and fed
//            back. The serial result is presented as a parallel WIDTH-bit sum
//            plus carry-out under a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Bit counter needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_co;
  logic             last_bit;

  // Single full-add stage on the current LSB pair.
  assign bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_co   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit = (cnt == CNT_LAST);

  // Result register shifts right with the new sum bit entering the MSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt = bit_s;
    end else begin : g_res_wn
      assign res_nxt = {bit_s, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial add datapath and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          carry  <= bit_co;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          cnt    <= cnt + CNT_ONE;
          // Sum/carry become visible only once the last bit is in.
          if (last_bit) begin
            sum   <= res_nxt;
            c_out <= bit_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
